// File: rtl/run_detector.sv
// Run-length detector: flags when serial input w has repeated RUN_LEN times,
// with polarity selection, a non-overlapping mode and a saturating match counter.
module run_detector #(
  parameter  int RUN_LEN = 2,
  parameter  int MATCH_W = 8,
  localparam int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               w,
  input  logic [1:0]         mode,
  output logic               z,
  output logic               last_bit,
  output logic [CNT_W-1:0]   run_out,
  output logic [MATCH_W-1:0] match_count
);

  localparam logic [CNT_W-1:0]   RUN_MAX   = CNT_W'(RUN_LEN);
  localparam logic [MATCH_W-1:0] MATCH_MAX = '1;

  localparam logic [1:0] MODE_EITHER  = 2'b00;
  localparam logic [1:0] MODE_ONES    = 2'b01;
  localparam logic [1:0] MODE_ZEROS   = 2'b10;
  localparam logic [1:0] MODE_NO_OVLP = 2'b11;

  logic               seen_q, seen_d;
  logic               last_bit_q, last_bit_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [MATCH_W-1:0] match_count_q, match_count_d;
  logic               polarity_ok;

  always_comb begin
    polarity_ok = 1'b1;
    case (mode)
      MODE_ONES:  polarity_ok = last_bit_q;
      MODE_ZEROS: polarity_ok = ~last_bit_q;
      default:    polarity_ok = 1'b1;
    endcase
  end

  // Moore decode: registered state plus the live mode input.
  assign z = seen_q & (run_q == RUN_MAX) & polarity_ok;

  always_comb begin
    seen_d        = seen_q;
    last_bit_d    = last_bit_q;
    run_d         = run_q;
    match_count_d = match_count_q;

    if (!seen_q) begin
      seen_d     = 1'b1;
      last_bit_d = w;
      run_d      = CNT_W'(1);
    end else if (mode == MODE_NO_OVLP && z) begin
      // Non-overlap restart: this sample opens a fresh run regardless of value.
      last_bit_d = w;
      run_d      = CNT_W'(1);
    end else if (w == last_bit_q) begin
      if (run_q != RUN_MAX) run_d = run_q + CNT_W'(1);
    end else begin
      last_bit_d = w;
      run_d      = CNT_W'(1);
    end

    if (z && match_count_q != MATCH_MAX) match_count_d = match_count_q + MATCH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q        <= 1'b0;
      last_bit_q    <= 1'b0;
      run_q         <= '0;
      match_count_q <= '0;
    end else begin
      seen_q        <= seen_d;
      last_bit_q    <= last_bit_d;
      run_q         <= run_d;
      match_count_q <= match_count_d;
    end
  end

  assign last_bit    = last_bit_q;
  assign run_out     = run_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed bench for run_detector: three instances cover RUN_LEN=2, RUN_LEN=3
// and a 2-bit saturating match counter.
module tb_run_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RUN_LEN=2, MATCH_W=8
  logic       ra, wa, za, lba;
  logic [1:0] ma, runa;
  logic [7:0] mca;
  // Instance B: RUN_LEN=3, MATCH_W=8
  logic       rb, wb, zb, lbb;
  logic [1:0] mb, runb;
  logic [7:0] mcb;
  // Instance C: RUN_LEN=2, MATCH_W=2
  logic       rc, wc, zc, lbc;
  logic [1:0] mc, runc;
  logic [1:0] mcc;

  run_detector #(.RUN_LEN(2), .MATCH_W(8)) dut_a (
    .clk(clk), .reset(ra), .w(wa), .mode(ma),
    .z(za), .last_bit(lba), .run_out(runa), .match_count(mca));

  run_detector #(.RUN_LEN(3), .MATCH_W(8)) dut_b (
    .clk(clk), .reset(rb), .w(wb), .mode(mb),
    .z(zb), .last_bit(lbb), .run_out(runb), .match_count(mcb));

  run_detector #(.RUN_LEN(2), .MATCH_W(2)) dut_c (
    .clk(clk), .reset(rc), .w(wc), .mode(mc),
    .z(zc), .last_bit(lbc), .run_out(runc), .match_count(mcc));

  int passes = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] seq_w;
    logic [5:0] seq_run_a [6];
    logic [5:0] exp_z;
    logic [5:0] exp_mc;

    ra = 1'b1; wa = 1'b0; ma = 2'b00;
    rb = 1'b1; wb = 1'b0; mb = 2'b01;
    rc = 1'b1; wc = 1'b0; mc = 2'b00;

    // Reset with w toggling
    tick(); wa = 1'b1;
    tick();
    chk("rst_z", za, 0);
    chk("rst_run", runa, 0);
    chk("rst_mc", mca, 0);
    chk("rst_lb", lba, 0);
    $display("reset idle: z=%0d run=%0d mc=%0d lb=%0d", za, runa, mca, lba);

    // RUN_LEN=2, mode 00, w = 0,0,1,1,1,0 (first listed sample is bit 0)
    seq_w  = 6'b011100;
    exp_z  = 6'b011010;
    exp_mc = 6'd0;
    seq_run_a = '{6'd1, 6'd2, 6'd1, 6'd2, 6'd2, 6'd1};
    ra = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wa = seq_w[i];
      tick();
      chk($sformatf("m00_run[%0d]", i), runa, seq_run_a[i]);
      chk($sformatf("m00_z[%0d]", i), za, exp_z[i]);
      $display("mode00 step %0d: w=%0d run=%0d z=%0d mc=%0d", i, wa, runa, za, mca);
    end
    chk("m00_mc_end", mca, 3);

    // RUN_LEN=2, mode 11, w=1 for 6 edges
    ra = 1'b1; tick(); ra = 1'b0;
    ma = 2'b11; wa = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("m11_z[%0d]", i), za, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("m11_run[%0d]", i), runa, (i % 2 == 1) ? 2 : 1);
      $display("mode11 step %0d: run=%0d z=%0d mc=%0d", i, runa, za, mca);
    end
    chk("m11_mc", mca, 2);

    // Live mode switch on a zero run
    ra = 1'b1; tick(); ra = 1'b0;
    ma = 2'b00; wa = 1'b0;
    tick(); tick();
    chk("sw_z00", za, 1);
    ma = 2'b01; #1;
    chk("sw_z01", za, 0);
    chk("sw_run", runa, 2);
    ma = 2'b10; #1;
    chk("sw_z10", za, 1);
    $display("mode switch: z=%0d run=%0d", za, runa);

    // RUN_LEN=3, mode 01, w = 0,0,0,1,1,1,1
    rb = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wb = (i >= 3);
      tick();
      chk($sformatf("b_z[%0d]", i), zb, (i >= 5) ? 1 : 0);
      chk($sformatf("b_run[%0d]", i), runb, (i < 3) ? i + 1 : ((i - 2 > 3) ? 3 : i - 2));
      $display("runlen3 step %0d: w=%0d run=%0d z=%0d mc=%0d", i, wb, runb, zb, mcb);
    end
    chk("b_mc7", mcb, 1);
    tick();
    chk("b_mc8", mcb, 2);

    // MATCH_W=2 saturation, mode 00, w=1 for 10 edges
    rc = 1'b0; wc = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("c_mc[%0d]", i), mcc, (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
      $display("sat step %0d: run=%0d z=%0d mc=%0d", i, runc, zc, mcc);
    end
    chk("c_run_sat", runc, 2);
    chk("c_z_sat", zc, 1);

    // Reset mid-run
    rc = 1'b1; tick();
    chk("c_rst_z", zc, 0);
    chk("c_rst_run", runc, 0);
    chk("c_rst_mc", mcc, 0);
    chk("c_rst_lb", lbc, 0);
    rc = 1'b0; tick();
    chk("c_post_run", runc, 1);
    chk("c_post_lb", lbc, 1);
    chk("c_post_z", zc, 0);
    $display("after reset: run=%0d lb=%0d z=%0d mc=%0d", runc, lbc, zc, mcc);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Parametrised successor to the team's lab sequence-detector FSM.
- Asserts `z` when serial input `w` has held the same value for `RUN_LEN` consecutive sampled cycles.
- Selectable polarity (ones, zeros or either) and an optional non-overlapping mode.
- Exposes the internal run state and a saturating match counter for board LEDs and debug.

Parameters:
- RUN_LEN, 2, consecutive equal samples required for a match; legal range 2..255.
- MATCH_W, 8, width of the saturating match counter.
- CNT_W, $clog2(RUN_LEN+1), width of the run counter; derived localparam, never overridden.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- w  input  1  serial data bit, sampled every rising clk edge.
- mode  input  2  00 either polarity; 01 runs of ones only; 10 runs of zeros only; 11 either polarity, non-overlapping.
- z  output  1  match flag; Moore output, decoded from registered state plus current mode.
- last_bit  output  1  most recently sampled w.
- run_out  output  CNT_W  current run length, saturating at RUN_LEN.
- match_count  output  MATCH_W  number of cycles z has been 1 since reset; saturating.

Behaviour:
- Registers: seen (1b), last_bit (1b), run (CNT_W), match_count (MATCH_W).
- Reset, sampled on a rising clk edge while reset=1, clears all of them:
  - seen=0, last_bit=0, run=0, match_count=0.
  - Therefore z=0 in the cycle after reset.
  - Reset overrides every other update, including a reset asserted mid-run.
- Edge update when reset=0, first matching rule wins:
  1. seen=0: seen<=1, last_bit<=w, run<=1.
  2. mode=11 and z=1: last_bit<=w, run<=1. This is the non-overlap restart; the current sample starts a new run whether or not it equals last_bit.
  3. w==last_bit: run<=min(run+1, RUN_LEN). Saturates at RUN_LEN; it never wraps.
  4. w!=last_bit: last_bit<=w, run<=1.
- z = seen & (run==RUN_LEN) & polarity_ok, where polarity_ok is:
  - mode 00 or 11: always true.
  - mode 01: last_bit=1.
  - mode 10: last_bit=0.
- Latency:
  - z rises in the cycle after the edge that samples the RUN_LEN-th equal bit.
  - In modes 00/01/10, z stays high for as long as the run continues (overlapping).
  - In mode 11, z is high for exactly one cycle per RUN_LEN equal samples.
- mode is combinational into z:
  - A mode change alters z in the same cycle.
  - Run tracking is mode-independent except for rule 2.
- match_count:
  - Increments by 1 at each rising edge where z=1 and reset=0.
  - Holds at 2^MATCH_W-1; it never wraps.
- No X propagation: all registers have defined reset values; outputs are pure functions of registers and mode.
- Implementation:
  - One always block for sequential state; z decode in a continuous assign.
  - run_out = run; last_bit is driven directly from its register.

Test Plan:
- Reset then idle: hold reset=1 for 2 edges with w toggling -> z=0, run_out=0, match_count=0, last_bit=0.
- RUN_LEN=2, mode=00, w sequence 0,0,1,1,1,0:
  - run_out after each edge = 1,2,1,2,2,1.
  - z after each edge = 0,1,0,1,1,0.
  - match_count ends at 3.
- RUN_LEN=3, mode=01, w=0,0,0,1,1,1,1 -> z=0 through the zero run; z=1 only after the 6th and 7th edges; match_count=1 after the 7th edge, 2 one edge later.
- RUN_LEN=2, mode=11, w=1 for 6 edges -> z pattern after each edge 0,1,0,1,0,1; run_out 1,2,1,2,1,2.
- Saturation and reset mid-run:
  - MATCH_W=2, mode=00, w held 1 for 10 edges -> match_count stops at 3 and run_out stays at RUN_LEN.
  - Then assert reset for one edge with w=1 -> all outputs 0 next cycle; the following edge gives run_out=1.
- Mode switch live: RUN_LEN=2, run of zeros with z=1 in mode 00, change mode to 01 -> z drops to 0 in the same cycle while run_out stays 2.
